sccb_target: RTL
================

# sccb_target

SCCB/I2C-style target (responder) that emulates the camera side of the register-configuration bus. It oversamples `sioc`/`siod` on the system clock, answers its device ID, and stores written bytes in an internal 256×8 register file. It returns register contents on read transactions. It sits opposite the camera controller's SCCB master, either in loopback benches or as a stand-in sensor, and reports every register write on a strobe port.

## Interface
Parameters:
- `SID`, default 8'h60. Device write address. The read address is `SID|1`, and only bits [7:1] are compared.
- `SYNC_STAGES`, default 2. Synchronizer depth on `sioc`/`siod`; minimum 2.

Ports:
- `clk` in 1: system clock, 50 MHz nominal. One clock; all logic is in this domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `sioc` in 1: SCCB clock from the master, asynchronous.
- `siod_in` in 1: sensed level of the SCCB data line, asynchronous.
- `siod_oe` out 1: when 1, the pad drives `siod` low (open-drain). When 0, the pad is released.
- `wr_valid` out 1: one-cycle strobe for each completed data-byte write.
- `wr_addr` out 8: register address of the write; valid with `wr_valid`.
- `wr_data` out 8: data byte of the write; valid with `wr_valid`.
- `busy` out 1: high from START detection to STOP detection.

## Operation
- Input conditioning: `sioc` and `siod_in` pass through `SYNC_STAGES` flops, followed by one edge-detect register.
- Bus events, evaluated on synced signals:
  - START: `siod` falls while `sioc` is high.
  - STOP: `siod` rises while `sioc` is high.
  - Data bits are sampled on the `sioc` rising edge, MSB first.
  - `siod_oe` changes only on `sioc` falling edges, except when STOP or reset releases it.
- States: IDLE, ID, ID_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
- IDLE → ID on START.
  - A START in any state, including a repeated START, goes to ID. The bit counter clears and `siod_oe` is released.
  - A STOP in any state goes to IDLE and releases `siod_oe`.
- ID: collect 8 bits.
  - If bits [7:1] ≠ `SID[7:1]`, go to IGNORE: no ACK, `siod_oe` stays 0 until the next START or STOP.
  - On a match, go to ID_ACK. On the next `sioc` fall, drive ACK (`siod_oe`=1) and hold it until the following fall.
  - After the ACK, go to REG if R/W=0, or RDATA if R/W=1.
- REG: collect 8 bits into the address pointer `ptr`. Then REG_ACK (ACK driven), then WDATA.
- WDATA: collect 8 bits.
  - On the 8th rising edge, write `mem[ptr]`, pulse `wr_valid` with `wr_addr=ptr` and `wr_data=byte`, and increment `ptr`.
  - Then WDATA_ACK (ACK driven), then WDATA again, so burst writes auto-increment.
- RDATA:
  - On entry, load a shift register with `mem[ptr]`.
  - On each `sioc` fall, set `siod_oe = ~bit`, MSB first.
  - After 8 bits, release on the next fall and go to RD_ACK.
- RD_ACK: sample the master bit on the `sioc` rise.
  - 0 (ACK): increment `ptr`, go to RDATA with the next byte.
  - 1 (NACK): go to IGNORE and wait for STOP or START.
- Pointer arithmetic: `ptr` is 8-bit and wraps 0xFF→0x00. `ptr` persists across transactions, so a write of only ID+REG followed by a read returns `mem[REG]`.
- Simultaneous events: if START/STOP and a data edge are detected in the same cycle, START/STOP wins.
- `mem` is not reset; its contents are undefined until written.

## Timing
Reset values:
- `siod_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `ptr`=0, state IDLE.
- Reset asserted mid-transfer releases `siod_oe` asynchronously.

Latency:
- A raw `sioc`/`siod` edge reaches a decision after `SYNC_STAGES`+1 clk.
- `siod_oe` updates `SYNC_STAGES`+2 clk after the raw `sioc` fall.

Other timing:
- `wr_valid` is high exactly 1 clk, `SYNC_STAGES`+2 clk after the raw 8th data-bit rise.
- Requirements on the master:
  - `sioc` high and low phases ≥ `SYNC_STAGES`+4 clk.
  - `siod` changes ≥ `SYNC_STAGES`+2 clk after the `sioc` fall.
  - These are met at 100–400 kHz SCCB with the 50 MHz clock.
- `busy` rises 1 clk after START detection and falls 1 clk after STOP detection.

## Test plan
- Single write:
  - Stimulus: START, 0x60, 0xFF, 0x01, STOP.
  - Response: ACK on all 3 bytes; one `wr_valid` with `wr_addr`=0xFF, `wr_data`=0x01; `busy` falls after STOP.
- Burst with wrap:
  - Stimulus: 0x60, 0xFE, 0xAA, 0xBB, 0xCC.
  - Response: writes (0xFE,AA), (0xFF,BB), (0x00,CC); 5 ACKs.
- Wrong ID:
  - Stimulus: START, 0x42, 0x10, 0x55, STOP.
  - Response: `siod_oe` never asserts; no `wr_valid`; the following valid 0x60 transaction works normally.
- Register read:
  - Stimulus: write 0x12←0x5A. Then START, 0x60, 0x12, STOP; START, 0x61; master ACKs the first byte and NACKs the second.
  - Response: bytes 0x5A then `mem[0x13]` are driven; `ptr`=0x14 after.
- Abort:
  - Stimulus: STOP after 4 bits of a data byte.
  - Response: no `wr_valid`, `siod_oe`=0, state IDLE.
  - Stimulus: repeated START mid-byte.
  - Response: restarts ID collection.
- Reset during a read while `siod_oe`=1:
  - Response: `siod_oe` drops immediately; all outputs return to reset values.

Source files
------------

// File: rtl/sccb_target.sv
// sccb_target: camera-side SCCB/I2C responder with a 256x8 register file,
// write strobe reporting and auto-incrementing register pointer.
`default_nettype none

module sccb_target #(
    parameter logic [7:0] SID         = 8'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sioc_sync_q, siod_sync_q;
    logic                   sioc_prev_q, siod_prev_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       mem_we;

    logic [7:0] mem [256];

    // Sync flops reset to the idle bus level so reset release never fakes an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_sync_q <= '1;
            siod_sync_q <= '1;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[SYNC_STAGES-2:0], sioc};
            siod_sync_q <= {siod_sync_q[SYNC_STAGES-2:0], siod_in};
            sioc_prev_q <= sioc_sync_q[SYNC_STAGES-1];
            siod_prev_q <= siod_sync_q[SYNC_STAGES-1];
        end
    end

    logic w_scl, w_sda, w_start, w_stop, w_rise, w_fall;
    logic [7:0] w_byte, w_rd_byte;

    assign w_scl     = sioc_sync_q[SYNC_STAGES-1];
    assign w_sda     = siod_sync_q[SYNC_STAGES-1];
    assign w_start   = w_scl & sioc_prev_q & siod_prev_q & ~w_sda;
    assign w_stop    = w_scl & sioc_prev_q & ~siod_prev_q & w_sda;
    assign w_rise    = w_scl & ~sioc_prev_q;
    assign w_fall    = ~w_scl & sioc_prev_q;
    assign w_byte    = {shift_q[6:0], w_sda};
    assign w_rd_byte = mem[ptr_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we     = 1'b0;
        if (w_start) begin
            state_d = S_ID;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            ack_d   = 1'b0;
            busy_d  = 1'b1;
        end else if (w_stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ID, S_REG, S_WDATA: if (w_rise) begin
                    shift_d = w_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        case (state_q)
                            S_ID: begin
                                if (w_byte[7:1] == SID[7:1]) begin
                                    state_d = S_ID_ACK;
                                    rw_d    = w_byte[0];
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end
                            S_REG: begin
                                ptr_d   = w_byte;
                                state_d = S_REG_ACK;
                            end
                            default: begin
                                mem_we     = 1'b1;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = ptr_q;
                                wr_data_d  = w_byte;
                                ptr_d      = ptr_q + 8'd1;
                                state_d    = S_WDATA_ACK;
                            end
                        endcase
                    end
                end
                // First fall drives the ACK, the second releases it and moves on
                S_ID_ACK, S_REG_ACK, S_WDATA_ACK: if (w_fall) begin
                    if (!ack_q) begin
                        oe_d  = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        oe_d  = 1'b0;
                        ack_d = 1'b0;
                        cnt_d = 4'd0;
                        if (state_q == S_ID_ACK && rw_q) begin
                            state_d = S_RDATA;
                            shift_d = w_rd_byte;
                            oe_d    = ~w_rd_byte[7];
                        end else if (state_q == S_ID_ACK) begin
                            state_d = S_REG;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_rise) begin
                        cnt_d   = cnt_q + 4'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end else if (w_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_RD_ACK;
                        end else begin
                            oe_d = ~shift_q[7];
                        end
                    end
                end
                // The pointer advances past every byte handed out, ACKed or not
                S_RD_ACK: begin
                    if (w_rise) begin
                        ptr_d = ptr_q + 8'd1;
                        if (w_sda) state_d = S_IGNORE;
                        else       ack_d   = 1'b1;
                    end else if (w_fall && ack_q) begin
                        ack_d   = 1'b0;
                        cnt_d   = 4'd0;
                        shift_d = w_rd_byte;
                        oe_d    = ~w_rd_byte[7];
                        state_d = S_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q] <= w_byte;
    end

    assign siod_oe  = oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

`default_nettype wire
